// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM encoding for the sequential ALU.
package alu_seq_pkg;

  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] OP_ADD = 3'b000;
  localparam logic [SEL_W-1:0] OP_SUB = 3'b001;
  localparam logic [SEL_W-1:0] OP_AND = 3'b010;
  localparam logic [SEL_W-1:0] OP_OR  = 3'b011;
  localparam logic [SEL_W-1:0] OP_XOR = 3'b100;
  localparam logic [SEL_W-1:0] OP_MUL = 3'b101;
  localparam logic [SEL_W-1:0] OP_CMP = 3'b110;
  localparam logic [SEL_W-1:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between operand fetch and writeback.
interface alu_seq_if
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [SEL_W-1:0] sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             carry;
  logic             overflow;
  logic             negative;
  logic             busy;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  zero, carry, overflow, negative, busy
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, result_hi,
    output zero, carry, overflow, negative, busy
  );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative shift-add unsigned multiplier, fixed WIDTH-cycle latency.
// hi/lo present the product as it will stand after the current edge; they are final when done=1.
module alu_seq_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic [WIDTH:0]   add;

  // acc_lo starts as the multiplier and is consumed LSB-first as product bits shift in
  always_comb begin
    add = {1'b0, acc_hi};
    if (acc_lo[0]) add = {1'b0, acc_hi} + {1'b0, mcand};
  end

  assign hi   = add[WIDTH:1];
  assign lo   = {add[0], acc_lo[WIDTH-1:1]};
  assign done = run && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= a;
      acc_hi <= '0;
      acc_lo <= b;
      cnt    <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc_hi <= hi;
      acc_lo <= lo;
      cnt    <= cnt + CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: handshake FSM, single-edge non-MUL datapath, iterative MUL, registered flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic             carry;
    logic             ovf;
  } alu_res_t;

  state_t           state, state_nxt;
  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;
  alu_res_t         alu_r;

  function automatic alu_res_t alu_eval(input logic [WIDTH-1:0] x,
                                        input logic [WIDTH-1:0] y,
                                        input logic [SEL_W-1:0] op);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    alu_res_t       r;
    sum  = {1'b0, x} + {1'b0, y};
    diff = {1'b0, x} - {1'b0, y};
    r    = '0;
    case (op)
      OP_ADD: begin
        r.lo    = sum[WIDTH-1:0];
        r.carry = sum[WIDTH];
        r.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        r.lo    = diff[WIDTH-1:0];
        r.carry = diff[WIDTH];
        r.ovf   = (x[WIDTH-1] != y[WIDTH-1]) && (diff[WIDTH-1] != x[WIDTH-1]);
      end
      OP_AND: r.lo = x & y;
      OP_OR:  r.lo = x | y;
      OP_XOR: r.lo = x ^ y;
      OP_CMP: begin
        r.lo    = {{(WIDTH-1){1'b0}}, (x == y)};
        r.carry = diff[WIDTH];
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = bus.in_valid & bus.in_ready;
  assign is_mul    = (bus.sel == OP_MUL);
  assign mul_start = accept & is_mul;
  assign alu_r     = alu_eval(bus.a, bus.b, bus.sel);

  alu_seq_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (bus.a),
    .b     (bus.b),
    .done  (mul_done),
    .hi    (mul_hi),
    .lo    (mul_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_mul ? MUL_RUN : DONE;
      MUL_RUN: if (mul_done) state_nxt = DONE;
      DONE: begin
        if (bus.out_ready) begin
          if (accept) state_nxt = is_mul ? MUL_RUN : DONE;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // in_ready looks through to out_ready so a draining result can be replaced on the same edge
  always_comb begin
    bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.zero      <= 1'b0;
      bus.carry     <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.negative  <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        bus.result    <= '0;
        bus.result_hi <= '0;
        bus.zero      <= 1'b0;
        bus.carry     <= 1'b0;
        bus.overflow  <= 1'b0;
        bus.negative  <= 1'b0;
      end else begin
        bus.result    <= alu_r.lo;
        bus.result_hi <= '0;
        bus.zero      <= (alu_r.lo == '0);
        bus.carry     <= alu_r.carry;
        bus.overflow  <= alu_r.ovf;
        bus.negative  <= alu_r.lo[WIDTH-1];
      end
    end else if ((state == MUL_RUN) && mul_done) begin
      bus.result    <= mul_lo;
      bus.result_hi <= mul_hi;
      bus.zero      <= (mul_lo == '0);
      bus.carry     <= (mul_hi != '0);
      bus.overflow  <= 1'b0;
      bus.negative  <= mul_lo[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq against an integer-arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;
  localparam int M = 1 << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: operands as plain integers, signed view only for overflow.
  function automatic void model(input int a, input int b, input int op,
                                output int lo, output int hi, output int c, output int v);
    int sa, sb, t;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    lo = 0; hi = 0; c = 0; v = 0;
    case (op)
      0: begin t = a + b; lo = t % M; c = (t >= M); v = (sa + sb > M/2 - 1) || (sa + sb < -M/2); end
      1: begin t = a - b; lo = (t + M) % M; c = (a < b); v = (sa - sb > M/2 - 1) || (sa - sb < -M/2); end
      2: lo = a & b;
      3: lo = a | b;
      4: lo = a ^ b;
      5: begin t = a * b; lo = t % M; hi = t / M; c = (hi != 0); end
      6: begin lo = (a == b) ? 1 : 0; c = (a < b); end
      default: lo = 0;
    endcase
  endfunction

  task automatic check_out(input string tag, input int a, input int b, input int op);
    int lo, hi, c, v;
    model(a, b, op, lo, hi, c, v);
    chk({tag, ".result"},    bus.result,    lo);
    chk({tag, ".result_hi"}, bus.result_hi, hi);
    chk({tag, ".zero"},      bus.zero,      (lo == 0));
    chk({tag, ".carry"},     bus.carry,     c);
    chk({tag, ".overflow"},  bus.overflow,  v);
    chk({tag, ".negative"},  bus.negative,  (lo >= M / 2));
  endtask

  // One transaction: accept, measure latency, check, optionally stall with junk input, then drain.
  task automatic txn(input string tag, input int a, input int b, input int op,
                     input int stall, input int exp_res, input int exp_hi);
    int lat;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin step(); guard++; end
    if (guard >= 20) chk({tag, ".in_ready_wait"}, bus.in_ready, 1);
    bus.a = a[W-1:0]; bus.b = b[W-1:0]; bus.sel = op[2:0]; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk({tag, ".busy"}, bus.busy, 1);
      step();
      lat++;
    end
    chk({tag, ".latency"}, lat, (op == int'(OP_MUL)) ? W + 1 : 1);
    check_out(tag, a, b, op);
    if (exp_res >= 0) chk({tag, ".exp_result"}, bus.result, exp_res);
    if (exp_hi >= 0)  chk({tag, ".exp_hi"},     bus.result_hi, exp_hi);
    for (int i = 0; i < stall; i++) begin
      bus.in_valid = 1'b1;
      bus.a = W'($urandom); bus.b = W'($urandom); bus.sel = OP_SUB;
      #1;
      chk({tag, ".stall_in_ready"}, bus.in_ready, 0);
      step();
      chk({tag, ".stall_out_valid"}, bus.out_valid, 1);
      check_out({tag, ".hold"}, a, b, op);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, ".drained"}, bus.out_valid, 0);
  endtask

  initial begin
    int ba[6], bb[6], bo[6];
    int ra, rb, ro;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sel = '0; bus.out_ready = 1'b0;

    step(); step();
    chk("reset.result",    bus.result, 0);
    chk("reset.result_hi", bus.result_hi, 0);
    chk("reset.zero",      bus.zero, 0);
    chk("reset.carry",     bus.carry, 0);
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.busy",      bus.busy, 0);
    chk("reset.in_ready",  bus.in_ready, 1);
    rst_n = 1'b1;
    step();

    txn("add_carry", 200, 100, 0, 0, 44, 0);
    txn("add_ovf",   8'h7F, 8'h01, 0, 0, 8'h80, 0);
    txn("sub_borrow", 5, 7, 1, 0, 8'hFE, 0);
    txn("mul",       8'h12, 8'h34, 5, 0, 8'hA8, 8'h03);
    txn("mul_ones",  8'hFF, 8'hFF, 5, 0, 1, M - 2);
    txn("mul_zero",  0, 8'hC3, 5, 0, 0, 0);
    txn("cmp_eq",    8'h33, 8'h33, 6, 0, 1, 0);
    txn("nop",       8'h55, 8'hAA, 7, 0, 0, 0);
    txn("backpress", 8'h81, 8'h92, 0, 5, 8'h13, 0);

    // back-to-back stream with out_ready held high: one result per cycle
    ba = '{8'h33, 8'h10, 200, 8'hF0, 8'h0F, 8'h80};
    bb = '{8'h33, 8'h20, 100, 8'h3C, 8'h0F, 8'h01};
    bo = '{6, 7, 0, 4, 1, 2};
    bus.out_ready = 1'b1;
    bus.a = ba[0][W-1:0]; bus.b = bb[0][W-1:0]; bus.sel = bo[0][2:0]; bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("b2b.out_valid", bus.out_valid, 1);
      check_out("b2b", ba[i], bb[i], bo[i]);
      if (i < 5) begin
        bus.a = ba[i+1][W-1:0]; bus.b = bb[i+1][W-1:0]; bus.sel = bo[i+1][2:0];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    step();
    chk("b2b.idle", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    // asynchronous reset in the middle of a multiply
    bus.a = 8'hAB; bus.b = 8'hCD; bus.sel = OP_MUL; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step(); step(); step();
    chk("rstmul.busy_before", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmul.result",    bus.result, 0);
    chk("rstmul.result_hi", bus.result_hi, 0);
    chk("rstmul.out_valid", bus.out_valid, 0);
    chk("rstmul.busy",      bus.busy, 0);
    chk("rstmul.in_ready",  bus.in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    txn("after_rst_add", 1, 1, 0, 0, 2, 0);

    for (int k = 0; k < 40; k++) begin
      ro = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? ((($urandom_range(0, 1)) != 0) ? M - 1 : M / 2) : $urandom_range(0, M - 1);
      rb = ($urandom_range(0, 3) == 0) ? ((($urandom_range(0, 1)) != 0) ? 0 : M / 2 - 1) : $urandom_range(0, M - 1);
      txn("rand", ra, rb, ro, $urandom_range(0, 2), -1, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
